// File: rtl/io_input_capture.sv
// Input capture for the DMA input path. Synchronises and debounces the apply button,
// and queues one IO_in sample per debounced press in a first-word-fall-through queue.
module io_input_capture #(
    parameter int DATA_W          = 22,
    parameter int DEPTH_LOG2      = 6,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_W-1:0]     IO_in,
    input  logic                  DMA_Apply_Btn,
    input  logic                  rd_en,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic [DEPTH_LOG2:0]   Input_Queue_Amount,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PW    = DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PW-1:0]    PTR_ONE = PW'(1);
    localparam logic [CW-1:0]    CNT_Q_ONE = CW'(1);
    localparam logic [CW-1:0]    FULL_CNT  = CW'(DEPTH);

    logic              btn_meta_q, btn_s_q;
    logic [DATA_W-1:0] io_meta_q, io_s_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              db_q, db_d;
    logic              db_prev_q;
    logic              push_q;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              overflow_q, overflow_d;

    logic              pop_s, full_s, push_ok_s, drop_s;

    // Two-stage synchronisers for the asynchronous button and switch/key bus
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
            io_meta_q  <= {DATA_W{1'b0}};
            io_s_q     <= {DATA_W{1'b0}};
        end else begin
            btn_meta_q <= DMA_Apply_Btn;
            btn_s_q    <= btn_meta_q;
            io_meta_q  <= IO_in;
            io_s_q     <= io_meta_q;
        end
    end

    // Debounce next state: the level is accepted only after DEBOUNCE_CYCLES stable disagreeing cycles
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (btn_s_q != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d  = btn_s_q;
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Debounce state and registered rising-edge push strobe
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= {CNT_W{1'b0}};
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            push_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            db_q      <= db_d;
            db_prev_q <= db_q;
            push_q    <= db_q & ~db_prev_q;
        end
    end

    // Queue control; a pop frees the slot, so push into a full queue succeeds when paired with a pop
    always_comb begin
        pop_s     = rd_en & rd_valid_q;
        full_s    = (count_q == FULL_CNT);
        push_ok_s = push_q & (~full_s | pop_s);
        drop_s    = push_q & full_s & ~pop_s;

        wr_ptr_d  = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d  = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_Q_ONE;
            2'b01:   count_d = count_q - CNT_Q_ONE;
            default: count_d = count_q;
        endcase

        rd_valid_d = (count_d != {CW{1'b0}});

        // Head is being written this cycle when the queue drains to exactly the incoming slot
        if (!rd_valid_d) begin
            rd_data_d = {DATA_W{1'b0}};
        end else if (push_ok_s && (wr_ptr_q == rd_ptr_d)) begin
            rd_data_d = io_s_q;
        end else begin
            rd_data_d = mem_q[rd_ptr_d];
        end

        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Queue storage; intentionally not reset
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= io_s_q;
        end
    end

    // Queue pointers, count and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            rd_valid_q <= 1'b0;
            rd_data_q  <= {DATA_W{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            overflow_q <= overflow_d;
        end
    end

    assign rd_valid           = rd_valid_q;
    assign rd_data            = rd_data_q;
    assign Input_Queue_Amount = count_q;
    assign overflow           = overflow_q;

endmodule

// File: tb/tb_io_input_capture.sv
// Directed self-checking bench for io_input_capture: debounce, FWFT ordering,
// full/overflow handling, pop-while-empty and asynchronous reset.
module tb_io_input_capture;

    logic        clock;
    logic        reset_n;
    logic [21:0] IO_in;
    logic        DMA_Apply_Btn;
    logic        rd_en;
    logic        rd_valid;
    logic [21:0] rd_data;
    logic [6:0]  Input_Queue_Amount;
    logic        overflow;
    logic        clr_overflow;

    int n_checks;
    int n_errors;

    io_input_capture #(
        .DATA_W          (22),
        .DEPTH_LOG2      (6),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .IO_in              (IO_in),
        .DMA_Apply_Btn      (DMA_Apply_Btn),
        .rd_en              (rd_en),
        .rd_valid           (rd_valid),
        .rd_data            (rd_data),
        .Input_Queue_Amount (Input_Queue_Amount),
        .overflow           (overflow),
        .clr_overflow       (clr_overflow)
    );

    // 100 MHz clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One clean press: push lands on the 8th edge, then a full release
    task automatic press_push(input logic [21:0] val);
        IO_in = val;
        DMA_Apply_Btn = 1'b1;
        tick(8);
        DMA_Apply_Btn = 1'b0;
        tick(8);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset_n       = 1'b0;
        IO_in         = 22'h0;
        DMA_Apply_Btn = 1'b0;
        rd_en         = 1'b0;
        clr_overflow  = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(2);

        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        check("rst_amount", 32'(Input_Queue_Amount), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // 1: single long press, exact latency
        IO_in = 22'h2A5A5;
        DMA_Apply_Btn = 1'b1;
        tick(7);
        check("t1_not_yet_valid", 32'(rd_valid), 32'd0);
        tick(1);
        check("t1_valid", 32'(rd_valid), 32'd1);
        check("t1_data", 32'(rd_data), 32'h0002A5A5);
        check("t1_amount", 32'(Input_Queue_Amount), 32'd1);
        tick(12);
        DMA_Apply_Btn = 1'b0;
        tick(10);
        check("t1_single_push", 32'(Input_Queue_Amount), 32'd1);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check("t1_pop_valid", 32'(rd_valid), 32'd0);
        check("t1_pop_data", 32'(rd_data), 32'd0);
        check("t1_pop_amount", 32'(Input_Queue_Amount), 32'd0);

        // 2: 3-cycle glitch is rejected; bouncy press yields one push
        IO_in = 22'h01234;
        DMA_Apply_Btn = 1'b1;
        tick(3);
        DMA_Apply_Btn = 1'b0;
        tick(15);
        check("t2_glitch_amount", 32'(Input_Queue_Amount), 32'd0);
        DMA_Apply_Btn = 1'b1; tick(1);
        DMA_Apply_Btn = 1'b0; tick(1);
        DMA_Apply_Btn = 1'b1;
        tick(14);
        DMA_Apply_Btn = 1'b0;
        tick(12);
        check("t2_bounce_amount", 32'(Input_Queue_Amount), 32'd1);
        check("t2_bounce_data", 32'(rd_data), 32'h00001234);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check("t2_drained", 32'(Input_Queue_Amount), 32'd0);

        // 3: fill with 0..63, continuous pop, pointers wrap
        for (int i = 0; i < 64; i++) press_push(22'(i));
        check("t3_full_amount", 32'(Input_Queue_Amount), 32'd64);
        check("t3_ovf_clear", 32'(overflow), 32'd0);
        rd_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            check("t3_order", 32'(rd_data), 32'(i));
            tick(1);
        end
        check("t3_empty_valid", 32'(rd_valid), 32'd0);
        check("t3_empty_amount", 32'(Input_Queue_Amount), 32'd0);
        tick(3);
        check("t3_rd_empty_amount", 32'(Input_Queue_Amount), 32'd0);
        check("t3_rd_empty_data", 32'(rd_data), 32'd0);
        check("t3_rd_empty_ovf", 32'(overflow), 32'd0);
        rd_en = 1'b0;

        // 4: overflow, clear, and push+pop while full
        for (int i = 0; i < 64; i++) press_push(22'(100 + i));
        press_push(22'h3FFFF);
        check("t4_amount", 32'(Input_Queue_Amount), 32'd64);
        check("t4_ovf_set", 32'(overflow), 32'd1);
        check("t4_head", 32'(rd_data), 32'd100);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        check("t4_ovf_clr", 32'(overflow), 32'd0);
        IO_in = 22'h1ABCD;
        DMA_Apply_Btn = 1'b1;
        tick(7);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check("t4_pp_amount", 32'(Input_Queue_Amount), 32'd64);
        check("t4_pp_ovf", 32'(overflow), 32'd0);
        check("t4_pp_head", 32'(rd_data), 32'd101);
        DMA_Apply_Btn = 1'b0;
        tick(8);
        rd_en = 1'b1;
        tick(63);
        rd_en = 1'b0;
        check("t4_tail_data", 32'(rd_data), 32'h0001ABCD);
        check("t4_tail_amount", 32'(Input_Queue_Amount), 32'd1);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check("t4_drained", 32'(Input_Queue_Amount), 32'd0);

        // 5: rd_en held high across a push into the empty queue
        rd_en = 1'b1;
        IO_in = 22'h00F0F;
        DMA_Apply_Btn = 1'b1;
        tick(8);
        check("t5_valid", 32'(rd_valid), 32'd1);
        check("t5_data", 32'(rd_data), 32'h00000F0F);
        check("t5_amount", 32'(Input_Queue_Amount), 32'd1);
        tick(1);
        check("t5_popped_valid", 32'(rd_valid), 32'd0);
        check("t5_popped_amount", 32'(Input_Queue_Amount), 32'd0);
        tick(3);
        check("t5_no_underflow", 32'(Input_Queue_Amount), 32'd0);
        check("t5_ovf", 32'(overflow), 32'd0);
        rd_en = 1'b0;
        DMA_Apply_Btn = 1'b0;
        tick(8);

        // 6: async reset mid-debounce with 5 entries stored
        for (int i = 0; i < 5; i++) press_push(22'(200 + i));
        check("t6_amount5", 32'(Input_Queue_Amount), 32'd5);
        IO_in = 22'h05555;
        DMA_Apply_Btn = 1'b1;
        tick(4);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(rd_valid), 32'd0);
        check("t6_rst_data", 32'(rd_data), 32'd0);
        check("t6_rst_amount", 32'(Input_Queue_Amount), 32'd0);
        check("t6_rst_ovf", 32'(overflow), 32'd0);
        DMA_Apply_Btn = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(15);
        check("t6_no_push_amount", 32'(Input_Queue_Amount), 32'd0);
        check("t6_no_push_valid", 32'(rd_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
